// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEND  = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    // First set bit of req at or above ptr, wrapping modulo n; one-hot, zero if none.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input int unsigned ptr,
                                                   input int unsigned n);
        logic [MAX_REQ-1:0] win;
        logic               found;
        logic [2:0]         k;
        win   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            k = 3'((ptr + i) % n);
            if (i < n && !found && req[k]) begin
                win[k] = 1'b1;
                found  = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin picker: rotates priority from ptr, yields one-hot winner and its index.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [MAX_REQ-1:0] pick;

    always_comb begin
        pick   = rr_pick(MAX_REQ'(req), 32'(ptr), NREQ);
        onehot = pick[NREQ-1:0];
        any    = |pick;
        idx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte streams with round-robin, packet-locked grants.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]        req_last,
    output logic [NREQ-1:0]        req_ready,
    output logic                   tx_valid,
    output logic [BYTE_W-1:0]      tx_data,
    input  logic                   tx_ready,
    input  logic                   tx_done,
    output logic [NREQ-1:0]        grant,
    output logic                   busy,
    output logic [7:0]             byte_cnt,
    output arb_state_t             dbg_state
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int TMO_W = $clog2(IDLE_TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  g_idx_q, g_idx_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [7:0]        byte_cnt_q, byte_cnt_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              last_q, last_d;
    logic              tx_valid_q, busy_q;
    logic              release_now;

    logic [NREQ-1:0]   arb_onehot;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (arb_onehot),
        .idx    (arb_idx),
        .any    (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        g_idx_d     = g_idx_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_d       = tmo_q;
        byte_cnt_d  = byte_cnt_q;
        tx_data_d   = tx_data_q;
        last_d      = last_q;
        release_now = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_onehot;
                    g_idx_d    = arb_idx;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                // req_ready is high for the owner here, so its valid alone completes the handshake.
                if (req_valid[g_idx_q]) begin
                    tx_data_d  = req_data[g_idx_q*BYTE_W +: BYTE_W];
                    last_d     = req_last[g_idx_q];
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    tmo_d      = '0;
                    state_d    = SEND;
                end else if (tmo_q == TMO_W'(IDLE_TIMEOUT - 1)) begin
                    release_now = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (last_q || byte_cnt_q == 8'(MAX_BURST)) begin
                        release_now = 1'b1;
                    end else begin
                        tmo_d   = '0;
                        state_d = GRANT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (release_now) begin
            rr_ptr_d   = (g_idx_q == IDX_W'(NREQ - 1)) ? '0 : g_idx_q + 1'b1;
            grant_d    = '0;
            byte_cnt_d = '0;
            tmo_d      = '0;
            state_d    = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            g_idx_q    <= '0;
            rr_ptr_q   <= '0;
            tmo_q      <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            g_idx_q    <= g_idx_d;
            rr_ptr_q   <= rr_ptr_d;
            tmo_q      <= tmo_d;
            byte_cnt_q <= byte_cnt_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tx_valid_q <= (state_d == SEND);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign req_ready = (state_q == GRANT) ? grant_q : '0;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign byte_cnt  = byte_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NREQ byte-stream requesters.
- Arbitration is round-robin with packet locking. A granted requester keeps the transmitter until it flags its last byte, hits MAX_BURST, or goes silent for IDLE_TIMEOUT cycles.
- Sits between client logic (command/response engines, debug print) and the uartTX valid/ready/tx_done interface.
- Serialises exactly one byte at a time; the next byte is never offered before tx_done of the previous one.

Parameters:
- NREQ, 4, number of requesters (2..8)
- MAX_BURST, 16, max bytes per grant before forced re-arbitration (1..255)
- IDLE_TIMEOUT, 1024, cycles a locked requester may idle in GRANT before release (>=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NREQ  per-requester byte valid
- req_data  in  8*NREQ  per-requester byte; requester i uses bits [8i+7:8i]
- req_last  in  NREQ  qualifies the byte as last of packet
- req_ready  out  NREQ  per-requester accept strobe
- tx_valid  out  1  byte offer to uartTX
- tx_data  out  8  byte to uartTX
- tx_ready  in  1  uartTX can accept
- tx_done  in  1  one-cycle pulse, stop bit finished
- grant  out  NREQ  one-hot current owner, 0 when idle
- busy  out  1  high in any state but IDLE
- byte_cnt  out  8  bytes sent in current grant

Behaviour:
- Interface: one clock domain on clk. rst is synchronous and active-high. All outputs are registered except req_ready, which is a decode of state and grant.
- Reset values: state=IDLE, grant=0, tx_valid=0, tx_data=0, byte_cnt=0, busy=0, req_ready=0, rr_ptr=0, timeout counter=0.
- IDLE:
  - Stay while req_valid==0.
  - Otherwise pick the first set bit scanning from rr_ptr upward, modulo NREQ.
  - Register the winner in grant. byte_cnt=0, go to GRANT next cycle.
- GRANT:
  - req_ready[g]=1 (owner only).
  - On req_valid[g]&req_ready[g]: capture data into tx_data, capture last into last_q, byte_cnt+=1, tmo=0, go to SEND. tx_valid=1 from the next cycle.
  - With no handshake, tmo+=1. When tmo reaches IDLE_TIMEOUT-1, release.
  - Valid from non-owners is ignored and held off.
- SEND:
  - tx_valid=1 and tx_data stable until the cycle tx_ready=1.
  - Then tx_valid=0, go to WAIT.
  - If tx_valid and tx_ready are both high on entry, the handshake completes that cycle.
- WAIT:
  - Hold until tx_done.
  - On tx_done: if last_q or byte_cnt==MAX_BURST, release. Otherwise return to GRANT with the same owner and tmo=0.
- Release:
  - rr_ptr=(g_index+1) mod NREQ, grant=0, byte_cnt=0, go to IDLE.
  - Minimum one IDLE cycle between grants.
- Latency: req handshake to tx_valid = 1 cycle. IDLE request to req_ready = 1 cycle.
- Fairness: a requester continuously asserting valid waits at most NREQ-1 grants.
- tx_done outside WAIT is ignored. tx_ready outside SEND is ignored.
- byte_cnt is 8-bit and never wraps, since MAX_BURST<=255.
- rst mid-operation: returns to IDLE immediately and drops tx_valid the next cycle. A byte already accepted by uartTX is not tracked.
- A requester deasserting valid mid-packet is legal; only timeout releases it.

Decomposition:
- Package uart_arb_pkg holds:
  - State enum IDLE/GRANT/SEND/WAIT (2 bits)
  - BYTE_W=8
  - Function rr_pick(req, ptr) returning a one-hot winner
- Sub-module rr_arbiter (NREQ): combinational priority rotate from rr_ptr giving a one-hot output and an index. It is reusable for a future RX demux.

Test Plan:
1. Single requester: req0 sends 0x55, 0xAA (last). Expect tx_data 0x55 then 0xAA, each offered only after the previous tx_done; grant=0001 through both, then 0000; rr_ptr=1.
2. Round-robin: all four requesters hold 1-byte last packets 0x10/0x21/0x32/0x43 from reset. Expect grant order 0,1,2,3; tx_data sequence 10,21,32,43; then back to 0 on re-request.
3. Packet lock: req1 sends 3 bytes 0x01, 0x02, 0x03 (last on 0x03) while req2 is valid. Expect no grant to req2 until after tx_done of 0x03.
4. MAX_BURST=4 with req0 streaming 10 bytes and no last, req1 waiting. Expect req0 released after the 4th tx_done with byte_cnt=4, then req1 granted.
5. Timeout (IDLE_TIMEOUT=8): req3 sends 1 byte without last, then drops valid. Expect release 8 cycles after returning to GRANT; grant=0, busy=0.
6. Reset mid-SEND with tx_ready held 0: expect tx_valid=0, grant=0, byte_cnt=0 the cycle after rst; a clean 0x7E transfer follows afterwards.
